// File: rtl/loop_seq_pkg.sv
// Shared types and default sizing for the nested-loop sequence generator.
package loop_seq_pkg;

    localparam int unsigned OUTER_N_DEF = 3;
    localparam int unsigned INNER_N_DEF = 3;
    localparam int unsigned CW_DEF      = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/loop_counter.sv
// Modulo-N counter with clear, enable and a terminal-count (wrap) flag.
module loop_counter #(
    parameter int unsigned N = 3,
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o,
    output logic         wrap_o
);

    localparam logic [W-1:0] LAST = W'(N - 1);
    localparam logic [W-1:0] ONE  = W'(1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // High while the count sits on its last value; the next enable wraps it.
    assign wrap_o = (cnt_q == LAST);
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/loop_seq_gen.sv
// Nested (i, j) loop beat generator with valid/ready output, a per-pass
// counter and a cumulative counter that survives across runs.
module loop_seq_gen
    import loop_seq_pkg::*;
#(
    parameter int unsigned OUTER_N = OUTER_N_DEF,
    parameter int unsigned INNER_N = INNER_N_DEF,
    parameter int unsigned CW      = CW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    out_i,
    output logic [7:0]    out_j,
    output logic [CW-1:0] auto_cnt,
    output logic [CW-1:0] static_cnt,
    output logic          busy,
    output logic          done
);

    if (OUTER_N < 1 || OUTER_N > 255) begin : g_bad_outer
        $error("loop_seq_gen: OUTER_N must be in 1..255");
    end
    if (INNER_N < 1 || INNER_N > 255) begin : g_bad_inner
        $error("loop_seq_gen: INNER_N must be in 1..255");
    end

    localparam logic [CW-1:0] ONE = CW'(1);

    state_e        state_q, state_d;
    logic [CW-1:0] auto_q, auto_d;
    logic [CW-1:0] static_q, static_d;
    logic          launch, hs, fin, adv;
    logic          i_wrap, j_wrap;

    assign launch = (state_q == IDLE) && start;
    assign hs     = (state_q == RUN) && out_ready;
    assign fin    = hs && i_wrap && j_wrap;
    // The final beat does not advance the counters, so i/j hold their last values.
    assign adv    = hs && !fin;

    loop_counter #(.N(INNER_N), .W(8)) u_j (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (adv),
        .clr_i  (launch),
        .cnt_o  (out_j),
        .wrap_o (j_wrap)
    );

    loop_counter #(.N(OUTER_N), .W(8)) u_i (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (adv && j_wrap),
        .clr_i  (launch),
        .cnt_o  (out_i),
        .wrap_o (i_wrap)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (fin)   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        auto_d   = auto_q;
        static_d = static_q;
        if (launch) begin
            auto_d   = ONE;
            static_d = static_q + ONE;
        end else if (adv) begin
            auto_d   = j_wrap ? ONE : auto_q + ONE;
            static_d = static_q + ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            auto_q   <= '0;
            static_q <= '0;
        end else begin
            state_q  <= state_d;
            auto_q   <= auto_d;
            static_q <= static_d;
        end
    end

    assign out_valid  = (state_q == RUN);
    assign busy       = (state_q == RUN);
    assign done       = (state_q == DONE);
    assign auto_cnt   = auto_q;
    assign static_cnt = static_q;

endmodule

// File: tb/tb_loop_seq_gen.sv
// Scoreboard bench: stimulus pushes expected beats, a negedge monitor pops and compares.
module tb_loop_seq_gen;

    typedef struct {
        int d;
        int i;
        int j;
        int ac;
        int sc;
        bit last;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n;
    logic st[2];
    logic rdy[2];

    logic       v0, b0, dn0, v1, b1, dn1;
    logic [7:0] i0, j0, ac0, sc0, i1, j1;
    logic [3:0] ac1, sc1;

    logic       o_valid[2], o_busy[2], o_done[2];
    logic [7:0] oi[2], oj[2], oac[2], osc[2];

    beat_t q[$];
    int    n_chk = 0;
    int    n_pass = 0;
    int    hs[2];
    bit    dpend[2];
    bit    dseen[2];
    int    msc[2];
    bit    mon_en = 1'b0;

    always #5 clk = ~clk;

    loop_seq_gen dut (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .out_valid(v0), .out_ready(rdy[0]),
        .out_i(i0), .out_j(j0), .auto_cnt(ac0), .static_cnt(sc0), .busy(b0), .done(dn0)
    );

    loop_seq_gen #(.OUTER_N(4), .INNER_N(5), .CW(4)) dut_w (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .out_valid(v1), .out_ready(rdy[1]),
        .out_i(i1), .out_j(j1), .auto_cnt(ac1), .static_cnt(sc1), .busy(b1), .done(dn1)
    );

    assign o_valid[0] = v0;  assign o_valid[1] = v1;
    assign o_busy[0]  = b0;  assign o_busy[1]  = b1;
    assign o_done[0]  = dn0; assign o_done[1]  = dn1;
    assign oi[0] = i0;       assign oi[1] = i1;
    assign oj[0] = j0;       assign oj[1] = j1;
    assign oac[0] = ac0;     assign oac[1] = {4'b0, ac1};
    assign osc[0] = sc0;     assign osc[1] = {4'b0, sc1};

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic check_zero(input int d);
        chk($sformatf("rst_valid%0d", d), int'(o_valid[d]), 0);
        chk($sformatf("rst_busy%0d", d), int'(o_busy[d]), 0);
        chk($sformatf("rst_done%0d", d), int'(o_done[d]), 0);
        chk($sformatf("rst_i%0d", d), int'(oi[d]), 0);
        chk($sformatf("rst_j%0d", d), int'(oj[d]), 0);
        chk($sformatf("rst_auto%0d", d), int'(oac[d]), 0);
        chk($sformatf("rst_static%0d", d), int'(osc[d]), 0);
    endtask

    // Reference: a run is the plain nested loop; cumulative count modulo 2^CW.
    task automatic push_run(input int d);
        int on, in, m;
        beat_t b;
        on = (d == 1) ? 4 : 3;
        in = (d == 1) ? 5 : 3;
        m  = (d == 1) ? 16 : 256;
        for (int i = 0; i < on; i++) begin
            for (int j = 0; j < in; j++) begin
                msc[d] = (msc[d] + 1) % m;
                b.d = d; b.i = i; b.j = j; b.ac = j + 1; b.sc = msc[d];
                b.last = (i == on - 1) && (j == in - 1);
                q.push_back(b);
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("done%0d", d), int'(o_done[d]), int'(dpend[d]));
                if (dpend[d]) chk($sformatf("busy_in_done%0d", d), int'(o_busy[d]), 0);
                dpend[d] = 1'b0;
                if (o_done[d]) dseen[d] = 1'b1;
                if (o_valid[d]) begin
                    if (q.size() == 0 || q[0].d != d) begin
                        n_chk++;
                        $display("FAIL unexpected_beat dut%0d: got i=%0d j=%0d expected no beat",
                                 d, oi[d], oj[d]);
                    end else begin
                        chk($sformatf("out_i%0d", d), int'(oi[d]), q[0].i);
                        chk($sformatf("out_j%0d", d), int'(oj[d]), q[0].j);
                        chk($sformatf("auto%0d", d), int'(oac[d]), q[0].ac);
                        chk($sformatf("static%0d", d), int'(osc[d]), q[0].sc);
                        chk($sformatf("busy%0d", d), int'(o_busy[d]), 1);
                        if (rdy[d]) begin
                            if (q[0].last) dpend[d] = 1'b1;
                            void'(q.pop_front());
                            hs[d]++;
                        end
                    end
                end
            end
        end
    end

    // mode: 0 ready=1, 1 random ready, 2 stall at (1,1), 3 start noise, 4 reset mid-run
    task automatic run(input int d, input int mode);
        bit fin = 1'b0;
        bit stalled = 1'b0;
        int low = 0;
        @(posedge clk); #1;
        hs[d] = 0;
        dseen[d] = 1'b0;
        st[d] = 1'b1;
        rdy[d] = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        push_run(d);
        for (int c = 0; c < 600 && !fin; c++) begin
            @(posedge clk); #1;
            if (dseen[d]) begin
                st[d] = 1'b0;
                rdy[d] = 1'b1;
                fin = 1'b1;
            end else if (mode == 4 && hs[d] >= 4) begin
                st[d] = 1'b0;
                #1 rst_n = 1'b0;
                #1;
                check_zero(0);
                check_zero(1);
                q.delete();
                dpend[0] = 1'b0; dpend[1] = 1'b0;
                msc[0] = 0; msc[1] = 0;
                #1 rst_n = 1'b1;
                fin = 1'b1;
            end else begin
                st[d] = (mode == 3) ? (o_done[d] | 1'($urandom_range(0, 1))) : 1'b0;
                if (mode == 1) begin
                    rdy[d] = ($urandom_range(0, 3) != 0);
                end else if (mode == 2) begin
                    if (!stalled && o_valid[d] && oi[d] == 8'd1 && oj[d] == 8'd1) begin
                        stalled = 1'b1;
                        low = 4;
                    end
                    if (low > 0) begin
                        rdy[d] = 1'b0;
                        low--;
                        chk("stall_auto", int'(oac[d]), 2);
                        chk("stall_static", int'(osc[d]), 5);
                    end else begin
                        rdy[d] = 1'b1;
                    end
                end else begin
                    rdy[d] = 1'b1;
                end
            end
        end
        if (!fin) begin
            n_chk++;
            $display("FAIL timeout dut%0d mode%0d: got no done expected done", d, mode);
        end
        if (mode == 2 && !stalled) begin
            n_chk++;
            $display("FAIL stall_point: got no beat (1,1) expected one");
        end
    endtask

    initial begin
        rst_n = 1'b0;
        st[0] = 1'b0; st[1] = 1'b0;
        rdy[0] = 1'b0; rdy[1] = 1'b0;
        for (int d = 0; d < 2; d++) begin
            hs[d] = 0; dpend[d] = 1'b0; dseen[d] = 1'b0; msc[d] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        check_zero(0);
        check_zero(1);
        rst_n = 1'b1;
        mon_en = 1'b1;

        run(0, 0);
        run(0, 3);
        repeat (5) @(posedge clk);
        run(0, 1);
        run(0, 4);
        repeat (5) @(posedge clk);
        run(0, 2);
        run(1, 0);
        run(1, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("wide_final_static", int'(osc[1]), 8);
        if (q.size() != 0) begin
            n_chk++;
            $display("FAIL leftover_beats: got %0d expected 0", q.size());
        end
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
